// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 fetch constants and the fetch-queue entry type
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry in-order queue, allocated at grant, filled on response, popped by decode
module fetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [XLEN-1:0] i_fill_instr,
  input  logic            i_pop,
  output logic [AW:0]     o_cnt,
  output logic [AW:0]     o_unfilled,
  output fq_entry_t       o_head
);
  fq_entry_t     r_q [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW:0]   r_cnt;
  logic [AW:0]   r_nfill;
  logic [AW-1:0] w_tail;
  logic [AW-1:0] w_fidx;
  // filled entries are always a prefix starting at the head
  assign w_tail     = r_head + r_cnt[AW-1:0];
  assign w_fidx     = r_head + r_nfill[AW-1:0];
  assign o_cnt      = r_cnt;
  assign o_unfilled = r_cnt - r_nfill;
  assign o_head     = r_q[r_head];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '{pc: RESET_PC, instr: '0, filled: 1'b0};
      r_head  <= '0;
      r_cnt   <= '0;
      r_nfill <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i].filled <= 1'b0;
      r_head  <= '0;
      r_cnt   <= '0;
      r_nfill <= '0;
    end else begin
      if (i_alloc) r_q[w_tail] <= '{pc: i_alloc_pc, instr: '0, filled: 1'b0};
      if (i_fill) begin
        r_q[w_fidx].instr  <= i_fill_instr;
        r_q[w_fidx].filled <= 1'b1;
      end
      if (i_pop) begin
        r_q[r_head].filled <= 1'b0;
        r_head             <= r_head + AW'(1);
      end
      r_cnt   <= r_cnt + (AW+1)'(i_alloc) - (AW+1)'(i_pop);
      r_nfill <= r_nfill + (AW+1)'(i_fill) - (AW+1)'(i_pop);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch controller driving next_pc/stallF, imem req/gnt/rvalid and the decode queue
// FETCH_PERF_CNT_EN adds saturating perf_fetched_o / perf_stall_o counters
module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            stall_o,
  input  logic            hz_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  input  logic            id_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 4;
  typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;
  state_t        r_state, w_state_n;
  logic [DW-1:0] r_disc, w_disc_n, w_out;
  logic [AW:0]   w_cnt, w_unfilled;
  fq_entry_t     w_head;
  logic          w_rv, w_drop, w_fill, w_pop, w_gnt;
  // w_out counts every response still owed by memory, stale or live
  assign w_out       = r_disc + DW'(w_unfilled);
  assign w_rv        = imem_rvalid_i && (w_out != '0);
  assign w_pop       = w_head.filled && id_ready_i && !redirect_i;
  assign imem_req_o  = !reset && !redirect_i && !hz_stall_i && ((w_cnt != (AW+1)'(DEPTH)) || w_pop);
  assign imem_addr_o = pc_i & ~32'd3;
  assign w_gnt       = imem_req_o && imem_gnt_i;
  assign stall_o     = reset || !(w_gnt || redirect_i);
  assign next_pc_o   = reset ? RESET_PC : redirect_i ? (redirect_pc_i & ~32'd3) : pc_i + PC_INC;
  assign id_valid_o  = w_head.filled;
  assign id_instr_o  = w_head.instr;
  assign id_pc_o     = w_head.pc;
  always_comb begin
    w_drop    = w_rv && (r_state == FLUSH);
    w_fill    = w_rv && (r_state != FLUSH) && !redirect_i;
    w_disc_n  = redirect_i ? w_out - DW'(w_rv) : r_disc - DW'(w_drop);
    w_state_n = (w_disc_n != '0) ? FLUSH : (imem_req_o ? RUN : WAIT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= RUN;
      r_disc  <= '0;
    end else begin
      r_state <= w_state_n;
      r_disc  <= w_disc_n;
    end
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (redirect_i),
    .i_alloc      (w_gnt),
    .i_alloc_pc   (imem_addr_o),
    .i_fill       (w_fill),
    .i_fill_instr (imem_rdata_i),
    .i_pop        (w_pop),
    .o_cnt        (w_cnt),
    .o_unfilled   (w_unfilled),
    .o_head       (w_head)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetched, r_stalls;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_fetched <= '0;
      r_stalls  <= '0;
    end else begin
      if (w_pop && r_fetched != '1) r_fetched <= r_fetched + 32'd1;
      if (stall_o && r_stalls != '1) r_stalls <= r_stalls + 32'd1;
    end
  assign perf_fetched_o = r_fetched;
  assign perf_stall_o   = r_stalls;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl with an in-order memory model
module tb_fetch_ctrl;
  localparam int DEPTH = 2;
  localparam int NEVER = 32'h7fff_ffff;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_i = '0, next_pc_o, redirect_pc_i = '0, imem_addr_o, imem_rdata_i = '0;
  logic [31:0] id_instr_o, id_pc_o;
  logic stall_o, hz_stall_i = 1'b0, redirect_i = 1'b0, imem_req_o, imem_gnt_i = 1'b0;
  logic imem_rvalid_i = 1'b0, id_valid_o, id_ready_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_stall_o;
`endif
  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .next_pc_o(next_pc_o), .stall_o(stall_o),
    .hz_stall_i(hz_stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .id_valid_o(id_valid_o),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_stall_o(perf_stall_o)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; int vis;} exp_t;
  typedef struct {logic [31:0] addr; int rdy; bit live;} mem_t;
  exp_t exp_q[$];
  mem_t mem_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, npop = 0, nstall = 0;
  bit stepped = 0, pend_stall = 0, first = 1;
  logic [31:0] pc = '0, pc_n = '0;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step(input int gp, input int rp, input int hp, input int dp,
                      input int lmin, input int lmax, input bit frd, input logic [31:0] ftgt);
    mem_t m;
    bit pop, req, gnt;
    int rdy;
    @(posedge clk);
    #1;
    nstall += int'(pend_stall);
    cyc++;
    pc = pc_n;
    pc_i = pc;
    imem_gnt_i = ($urandom_range(99) < gp);
    id_ready_i = ($urandom_range(99) < rp);
    hz_stall_i = ($urandom_range(99) < hp);
    redirect_i = frd || ($urandom_range(99) < dp);
    redirect_pc_i = frd ? ftgt : $urandom;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = $urandom;
    if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
      m = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i = ins(m.addr);
      if (m.live)
        for (int i = 0; i < exp_q.size(); i++)
          if (exp_q[i].vis == NEVER) begin
            exp_q[i].vis = cyc + 1;
            break;
          end
    end else if (mem_q.size() == 0 && $urandom_range(9) == 0) imem_rvalid_i = 1'b1;
    stepped = 1;
    #1;
    pop = exp_q.size() > 0 && exp_q[0].vis <= cyc && id_ready_i && !redirect_i;
    req = !redirect_i && !hz_stall_i && (exp_q.size() - int'(pop) < DEPTH);
    gnt = req && imem_gnt_i;
    chk("req", 32'(imem_req_o), 32'(req));
    if (req) chk("addr", imem_addr_o, pc);
    chk("stall", 32'(stall_o), 32'(!(gnt || redirect_i)));
    chk("next_pc", next_pc_o, redirect_i ? (redirect_pc_i & 32'hFFFF_FFFC) : pc + 32'd4);
    pend_stall = !(gnt || redirect_i);
    if (redirect_i) foreach (mem_q[i]) mem_q[i].live = 0;
    if (gnt) begin
      exp_q.push_back('{pc: pc, vis: NEVER});
      rdy = cyc + $urandom_range(lmax, lmin);
      if (mem_q.size() > 0 && mem_q[$].rdy >= rdy) rdy = mem_q[$].rdy + 1;
      mem_q.push_back('{addr: pc, rdy: rdy, live: 1});
    end
    pc_n = redirect_i ? (redirect_pc_i & 32'hFFFF_FFFC) : gnt ? pc + 32'd4 : pc;
  endtask

  task automatic do_reset();
    #1;
`ifdef FETCH_PERF_CNT_EN
    if (!first) begin
      chk("perf_fetched", perf_fetched_o, 32'(npop));
      chk("perf_stall", perf_stall_o, 32'(nstall));
    end
`endif
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd1);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_next_pc", next_pc_o, 32'h0);
    chk("rst_id_pc", id_pc_o, 32'h0);
    chk("rst_id_instr", id_instr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched_o, 32'h0);
    chk("rst_perf_stall", perf_stall_o, 32'h0);
`endif
    first = 0;
    stepped = 0;
    exp_q.delete();
    mem_q.delete();
    pc = '0; pc_n = '0; pc_i = '0;
    imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; hz_stall_i = 0; id_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    npop = 0; nstall = 0; pend_stall = 1; cyc = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (stepped) begin
      stepped = 0;
      if (!reset) begin
        chk("id_valid", 32'(id_valid_o), 32'(exp_q.size() > 0 && exp_q[0].vis <= cyc));
        if (id_valid_o && id_ready_i && !redirect_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stale: decode got pc %h, expected no instruction", id_pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc_o, e.pc);
            chk("id_instr", id_instr_o, ins(e.pc));
            npop++;
          end
        end
        if (redirect_i) exp_q.delete();
      end
    end
  end

  initial begin
    do_reset();
    repeat (12) step(100, 100, 0, 0, 1, 1, 0, 0);
    do_reset();
    repeat (6) step(100, 0, 0, 0, 1, 1, 0, 0);
    chk("bp_pc_held", imem_addr_o, 32'h8);
    chk("bp_req_low", 32'(imem_req_o), 32'd0);
    repeat (6) step(100, 100, 0, 0, 1, 1, 0, 0);
    do_reset();
    repeat (2) step(100, 100, 0, 0, 3, 3, 0, 0);
    step(100, 100, 0, 0, 3, 3, 1, 32'h103);
    chk("redir_next_pc", next_pc_o, 32'h100);
    step(100, 100, 0, 0, 1, 1, 0, 0);
    chk("redir_addr", imem_addr_o, 32'h100);
    repeat (10) step(100, 100, 0, 0, 1, 1, 0, 0);
    do_reset();
    step(100, 100, 0, 0, 1, 1, 1, 32'hFFFF_FFFC);
    step(100, 100, 0, 0, 1, 1, 0, 0);
    chk("wrap", next_pc_o, 32'h0);
    repeat (6) step(100, 100, 0, 0, 1, 2, 0, 0);
    do_reset();
    repeat (3000) step(70, 60, 15, 8, 1, 3, 0, 0);
    do_reset();
    repeat (2) step(100, 0, 0, 0, 3, 3, 0, 0);
    do_reset();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
